// File: rtl/ks8_pkg.sv
// Shared definitions for the byte-serial Kogge-Stone add sequencer.
package ks8_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/koggstone8.sv
// 8-bit Kogge-Stone parallel-prefix adder with carry-in, purely combinational.
module koggstone8 (
   output logic [7:0] s,
   output logic       co,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       ci
);

   logic [7:0] g_l [4];
   logic [7:0] p_l [4];
   logic [8:0] c;

   // Three prefix levels (span 1, 2, 4), then fold the carry-in into every group carry.
   always_comb begin
      g_l[0] = a & b;
      p_l[0] = a ^ b;
      for (int lvl = 1; lvl < 4; lvl++) begin
         g_l[lvl] = g_l[lvl-1];
         p_l[lvl] = p_l[lvl-1];
         for (int i = (1 << (lvl - 1)); i < 8; i++) begin
            g_l[lvl][i] = g_l[lvl-1][i] | (p_l[lvl-1][i] & g_l[lvl-1][i-(1 << (lvl - 1))]);
            p_l[lvl][i] = p_l[lvl-1][i] & p_l[lvl-1][i-(1 << (lvl - 1))];
         end
      end
      c    = '0;
      c[0] = ci;
      for (int i = 1; i < 9; i++) begin
         c[i] = g_l[3][i-1] | (p_l[3][i-1] & ci);
      end
      s  = p_l[0] ^ c[7:0];
      co = c[8];
   end

endmodule

// File: rtl/ks8_add_sequencer.sv
// Byte-serial multi-precision adder: one shared 8-bit Kogge-Stone slice,
// LSB byte first, inter-byte carry held only in carry_q.
module ks8_add_sequencer
   import ks8_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [8*NBYTES-1:0]     a,
   input  logic [8*NBYTES-1:0]     b,
   input  logic                    ci,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [8*NBYTES-1:0]     sum,
   output logic                    co,
   output logic                    busy
);

   localparam int W     = BYTE_W * NBYTES;
   localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [W-1:0]       sum_q, sum_d;
   logic               co_q, co_d;
   logic               in_ready_q, out_valid_q, busy_q;

   logic [BYTE_W-1:0]  a_byte, b_byte, s_byte;
   logic               co_byte;

   // Select the operand byte slice currently being added.
   always_comb begin
      a_byte = '0;
      b_byte = '0;
      for (int k = 0; k < NBYTES; k++) begin
         if (idx_q == IDX_W'(k)) begin
            a_byte = a_q[k*BYTE_W +: BYTE_W];
            b_byte = b_q[k*BYTE_W +: BYTE_W];
         end
      end
   end

   koggstone8 u_add (
      .s  (s_byte),
      .co (co_byte),
      .a  (a_byte),
      .b  (b_byte),
      .ci (carry_q)
   );

   // Controller next-state: accept in IDLE, one byte per cycle in ADD, hold in DONE.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      co_d    = co_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = ci;
               idx_d   = '0;
               sum_d   = '0;
               co_d    = 1'b0;
               state_d = ST_ADD;
            end
         end
         ST_ADD: begin
            for (int k = 0; k < NBYTES; k++) begin
               if (idx_q == IDX_W'(k)) sum_d[k*BYTE_W +: BYTE_W] = s_byte;
            end
            carry_d = co_byte;
            if (idx_q == LAST_IDX) begin
               co_d    = co_byte;
               idx_d   = '0;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, datapath registers and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         co_q        <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         co_q        <= co_d;
         in_ready_q  <= (state_d == ST_IDLE);
         out_valid_q <= (state_d == ST_DONE);
         busy_q      <= (state_d != ST_IDLE);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sum       = sum_q;
   assign co        = co_q;

endmodule
